// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the fetch PC and selects the next PC from one of four sources:
// sequential (npc_seq from the external NPC block), branch, jump or
// jump-register. It drives the instruction-memory address and holds the
// IF/ID pipeline register.
//
// Control transfers are resolved in D. The architecture has one delay slot,
// so a redirect never squashes the instruction that is already fetched.
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   stall      in   1   hold PC and IF/ID
//   flush      in   1   turn IF/ID into a bubble (overrides stall for IF/ID)
//   npc_sel    in   2   00 seq, 01 branch, 10 j/jal, 11 jr/jalr
//   imm16      in  16   branch offset of the instruction in D
//   imm26      in  26   jump index of the instruction in D
//   rs_val     in  32   forwarded rs value for jr/jalr
//   npc_seq    in  32   pc_F + 4 computed by the NPC block
//   pc_F       out 32   current fetch PC (also feeds the NPC block)
//   im_addr    out 32   instruction-memory address, equal to pc_F
//   im_rdata   in  32   instruction word, asynchronous read
//   instr_D    out 32   IF/ID instruction
//   pc_D       out 32   IF/ID address of instr_D
//   pc8_D      out 32   IF/ID link value pc_D + 8
//   valid_D    out  1   IF/ID holds a real instruction
//   err_D      out  1   IF/ID came from a misaligned / out-of-window fetch
//   fetch_cnt  out 32   count of valid instructions loaded into IF/ID
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_sel,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_val,
    input  logic [31:0] npc_seq,
    output logic [31:0] pc_F,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        valid_D,
    output logic        err_D,
    output logic [31:0] fetch_cnt
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_J   = 2'b10;
    localparam logic [1:0] SEL_JR  = 2'b11;

    // One extra bit so IM_BASE + IM_SIZE cannot wrap at the top of memory.
    localparam logic [XLEN:0] IM_END = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

    // IF/ID pipeline register payload.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc8;
        logic            valid;
        logic            err;
    } ifid_t;

    logic [XLEN-1:0] pc_q, pc_d;
    ifid_t           ifid_q, ifid_d;
    logic [XLEN-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] j_tgt;
    logic [XLEN-1:0] jr_tgt;
    logic [XLEN-1:0] next_pc;
    logic            fetch_err;

    // Redirect targets, all relative to the instruction currently in D.
    always_comb begin
        br_off = {{14{imm16[15]}}, imm16, 2'b00};
        br_tgt = ifid_q.pc + XLEN'(4) + br_off;
        j_tgt  = {ifid_q.pc[31:28], imm26, 2'b00};
        jr_tgt = rs_val;
    end

    // Next-PC select; a redirect from an empty D slot falls back to sequential.
    always_comb begin
        next_pc = npc_seq;
        if (ifid_q.valid) begin
            unique case (npc_sel)
                SEL_SEQ: next_pc = npc_seq;
                SEL_BR:  next_pc = br_tgt;
                SEL_J:   next_pc = j_tgt;
                SEL_JR:  next_pc = jr_tgt;
                default: next_pc = npc_seq;
            endcase
        end
    end

    // Fetch fault: misaligned, below the window or at/after its end.
    always_comb begin
        fetch_err = (pc_q[1:0] != 2'b00)
                 || (pc_q < IM_BASE)
                 || ({1'b0, pc_q} >= IM_END);
    end

    // PC next state: stall freezes the PC and drops any redirect.
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            pc_d = next_pc;
        end
    end

    // IF/ID next state and fetch counter; flush beats stall here only.
    always_comb begin
        ifid_d = ifid_q;
        cnt_d  = cnt_q;
        if (flush) begin
            ifid_d.instr = '0;
            ifid_d.valid = 1'b0;
            ifid_d.err   = 1'b0;
        end else if (!stall) begin
            ifid_d.instr = fetch_err ? '0 : im_rdata;
            ifid_d.pc    = pc_q;
            ifid_d.pc8   = pc_q + XLEN'(8);
            ifid_d.valid = 1'b1;
            ifid_d.err   = fetch_err;
            cnt_d        = cnt_q + XLEN'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            ifid_q <= '0;
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pc_F      = pc_q;
    assign im_addr   = pc_q;
    assign instr_D   = ifid_q.instr;
    assign pc_D      = ifid_q.pc;
    assign pc8_D     = ifid_q.pc8;
    assign valid_D   = ifid_q.valid;
    assign err_D     = ifid_q.err;
    assign fetch_cnt = cnt_q;

endmodule
